// File: rtl/outport_alloc.sv
// -----------------------------------------------------------------------------
// outport_alloc
//   Wormhole output-port allocator for one router output. The input ports
//   compete for this output. The allocator picks a winner by round-robin and
//   locks the crossbar select to it until the packet's tail flit has gone
//   through. It also tracks the downstream buffer credits.
//
//   Ports
//     clk        : single clock, rising edge
//     rst_       : asynchronous, active-low reset
//     port       : per-input destination field, input k in [k*PORTW +: PORTW]
//     req        : per-input valid flit
//     tail       : per-input "current flit is the last of its packet"
//     credit_in  : one-cycle pulse, downstream freed a buffer slot
//     sel        : registered one-hot crossbar select (zero when idle)
//     grt        : combinational per-cycle flit accept (at most one bit)
//     credit_cnt : available downstream credits
//     busy       : a packet currently holds the output
//     cred_ovf   : sticky, credit returned while the count was already full
// -----------------------------------------------------------------------------

// Per-input candidate qualifier: the input is valid and targets this output.
// The input at index PORTID is excluded when u-turns are disabled.
module outport_alloc_cand #(
   parameter int PORTW  = 3,
   parameter int PORTID = 0,
   parameter int UTURN  = 1,
   parameter int IDX    = 0
) (
   input  logic             req,
   input  logic [PORTW-1:0] port,
   output logic             cand
);
   localparam bit ALLOWED = (UTURN != 0) || (IDX != PORTID);

   assign cand = ALLOWED && req && (port == PORTW'(PORTID));
endmodule

module outport_alloc #(
   parameter  int NPORT   = 5,
   parameter  int PORTW   = 3,
   parameter  int PORTID  = 0,
   parameter  int CREDITS = 4,
   parameter  int UTURN   = 1,
   localparam int CW      = $clog2(CREDITS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT*PORTW-1:0] port,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT-1:0]       tail,
   input  logic                   credit_in,
   output logic [NPORT-1:0]       sel,
   output logic [NPORT-1:0]       grt,
   output logic [CW-1:0]          credit_cnt,
   output logic                   busy,
   output logic                   cred_ovf
);
   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [NPORT-1:0] sel_q, sel_d;
   logic [PW-1:0]    own_q, own_d;   // index of the input holding the output
   logic [PW-1:0]    ptr_q, ptr_d;   // last served input; search starts at ptr+1
   logic [CW-1:0]    cred_q, cred_d;
   logic             ovf_q, ovf_d;

   logic [NPORT-1:0] cand;
   logic [PW-1:0]    win_idx;
   logic             win_vld;
   logic [NPORT-1:0] win_oh;
   logic             xfer;
   logic             tail_hit;

   // Candidate qualification, one instance per input
   for (genvar k = 0; k < NPORT; k++) begin : g_cand
      outport_alloc_cand #(
         .PORTW  (PORTW),
         .PORTID (PORTID),
         .UTURN  (UTURN),
         .IDX    (k)
      ) u_cand (
         .req  (req[k]),
         .port (port[k*PORTW +: PORTW]),
         .cand (cand[k])
      );
   end

   // Round-robin search from ptr+1 upward, modulo NPORT. The loop walks the
   // offsets from farthest to nearest so the nearest candidate is written last
   // and wins.
   always_comb begin
      int k;
      k       = 0;
      win_idx = '0;
      win_vld = 1'b0;
      for (int i = NPORT; i >= 1; i--) begin
         k = (int'(ptr_q) + i) % NPORT;
         if (cand[PW'(k)]) begin
            win_idx = PW'(k);
            win_vld = 1'b1;
         end
      end
   end

   assign win_oh = {{(NPORT-1){1'b0}}, 1'b1} << win_idx;

   // A flit moves only while locked, when the owner presents one and a
   // downstream slot is free. A dropped req keeps the lock and yields no grant.
   assign grt      = (state_q == LOCKED && cred_q != '0) ? (sel_q & req) : '0;
   assign xfer     = |grt;
   assign tail_hit = |(grt & tail);

   // FSM next state and select/pointer updates
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            // Arbitration does not depend on the credit count
            if (win_vld) begin
               state_d = LOCKED;
               sel_d   = win_oh;
               own_d   = win_idx;
            end
         end
         LOCKED: begin
            if (tail_hit) begin
               state_d = IDLE;
               sel_d   = '0;
               ptr_d   = own_q;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // Credit counter. A transfer and a returned credit in the same cycle
   // cancel out. A lone return at a full count saturates the count and
   // raises the sticky overflow flag.
   always_comb begin
      cred_d = cred_q;
      ovf_d  = ovf_q;
      if (xfer && !credit_in) begin
         cred_d = cred_q - CW'(1);
      end else if (credit_in && !xfer) begin
         if (cred_q == CW'(CREDITS)) ovf_d  = 1'b1;
         else                        cred_d = cred_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= IDLE;
         sel_q   <= '0;
         own_q   <= '0;
         ptr_q   <= PW'(NPORT - 1);
         cred_q  <= CW'(CREDITS);
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         cred_q  <= cred_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sel        = sel_q;
   assign busy       = (state_q == LOCKED);
   assign credit_cnt = cred_q;
   assign cred_ovf   = ovf_q;

endmodule

// File: doc/outport_alloc.md
OUTPORT_ALLOC -- requirements
Module: outport_alloc

Interface
REQ-001 SHALL have parameter NPORT, default 5: number of router input ports competing for this output.
REQ-002 SHALL have parameter PORTW, default 3: width of each destination-port field.
REQ-003 SHALL have parameter PORTID, default 0: index of the output port this instance controls.
REQ-004 SHALL have parameter CREDITS, default 4: downstream buffer depth in flits; CW = clog2(CREDITS+1).
REQ-005 SHALL have parameter UTURN, default 1: when 0, requests from input index PORTID are ignored.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_  input  1  reset, asynchronous, active-low.
REQ-008 port  input  NPORT*PORTW  destination of input k's current flit, in bits [k*PORTW +: PORTW].
REQ-009 req  input  NPORT  input k presents a valid flit.
REQ-010 tail  input  NPORT  input k's current flit is the last of its packet.
REQ-011 credit_in  input  1  downstream freed one buffer slot (one-cycle pulse).
REQ-012 sel  output  NPORT  registered one-hot crossbar select; all-zero when idle.
REQ-013 grt  output  NPORT  combinational per-cycle flit accept, at most one bit set.
REQ-014 credit_cnt  output  CW  available downstream credits.
REQ-015 busy  output  1  high while a packet holds the output (state LOCKED).
REQ-016 cred_ovf  output  1  sticky flag: credit_in received with the counter already at CREDITS.

Function
REQ-017 SHALL treat input k as a candidate when req[k]=1 and port field k = PORTID (and k != PORTID if UTURN=0).
REQ-018 SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-019 IDLE: when at least one candidate exists at a rising edge, SHALL select the winner by round-robin, searching from ptr+1 upward modulo NPORT; SHALL load sel one-hot and enter LOCKED; the credit count does not gate arbitration.
REQ-020 Arbitration latency SHALL be exactly one cycle: a candidate sampled at edge n drives sel/busy after edge n; no grt in IDLE.
REQ-021 LOCKED: grt SHALL equal sel & req & (credit_cnt != 0); a set grt bit marks one flit transferred that cycle.
REQ-022 LOCKED: when req drops without tail, sel SHALL hold (wormhole lock) and grt SHALL be 0.
REQ-023 LOCKED: a transfer with tail[w]=1 SHALL return the FSM to IDLE, set ptr=w, and clear sel at the next edge.
REQ-024 A single-flit packet (head with tail=1) SHALL occupy exactly one LOCKED cycle when credit is available.
REQ-025 One idle bubble cycle SHALL separate consecutive packets; the next winner is chosen in that IDLE cycle.
REQ-026 Port fields of non-winning inputs and of the winner after lock SHALL NOT affect sel while LOCKED.
REQ-027 credit_cnt: a transfer alone decrements by 1; credit_in alone increments by 1; both together leave it unchanged.
REQ-028 credit_in alone at CREDITS SHALL saturate the count and set cred_ovf, which stays set until reset.
REQ-029 A transfer SHALL NOT occur at credit_cnt=0; the count never underflows.

Reset
REQ-030 rst_=0 SHALL immediately force: state IDLE, sel=0, busy=0, grt=0, ptr=NPORT-1 (input 0 has first priority), credit_cnt=CREDITS, cred_ovf=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from the REQ-030 state.

Verification
REQ-032 Reset, then req[2]=1 with port2=PORTID, tail[2]=0 for 3 cycles, then tail[2]=1 -> sel=00100 from the cycle after the first request, grt[2] for 4 cycles, credit_cnt 4->0, busy drops after the tail.
REQ-033 req[1] and req[3] requested simultaneously, single-flit packets, repeated -> grants alternate 1,3,1,3 with one bubble cycle between packets.
REQ-034 Hold credit_in=0 through a 6-flit packet -> grt stops after 4 flits with sel held; one credit_in pulse -> exactly one more grt.
REQ-035 req[0] with port0 != PORTID -> no sel and no grt; UTURN=0 with req[PORTID] targeting PORTID -> ignored.
REQ-036 Assert rst_=0 mid-packet -> sel=0, busy=0 and credit_cnt=4 at once; credit_in at full count -> cred_ovf=1, count stays 4.
